// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, default widths and small op-classification helpers.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int RADDR_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // MUL only needs the low half, which is identical for signed and unsigned.
    function automatic logic op_rs1_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_rs2_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side handshake of the multiply/divide unit; the execute stage is
// the master, ex_muldiv is the slave.
interface ex_muldiv_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               start;
    logic [2:0]         op;
    logic [XLEN-1:0]    opv1;
    logic [XLEN-1:0]    opv2;
    logic [RADDR_W-1:0] reg_waddr_i;
    logic               cancel;
    logic               stallreq;
    logic               valid_o;
    logic [XLEN-1:0]    result;
    logic [RADDR_W-1:0] reg_waddr_o;

    modport master (
        output start, op, opv1, opv2, reg_waddr_i, cancel,
        input  stallreq, valid_o, result, reg_waddr_o
    );

    modport slave (
        input  start, op, opv1, opv2, reg_waddr_i, cancel,
        output stallreq, valid_o, result, reg_waddr_o
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// One-bit-per-cycle datapath on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide, plus the iteration counter.
module ex_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            last
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  b_q;
    logic [XLEN:0]    add_sum;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    // hi stays below the divisor, so diff[XLEN] is exactly the borrow.
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        last    = (cnt == CNT_W'(XLEN - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
            b_q <= '0;
        end else if (load) begin
            cnt <= '0;
            hi  <= '0;
            lo  <= a;
            b_q <= b;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
                if (!diff[XLEN]) begin
                    hi <= diff[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b1};
                end else begin
                    hi <= shifted[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
            end else begin
                hi <= add_sum[XLEN:1];
                lo <= {add_sum[0], lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M-style iterative multiply/divide unit: FSM, operand sign handling,
// special-case bypass and result hold registers around ex_muldiv_iter.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int RADDR_W = RADDR_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e             state, state_nx;
    op_e                op_in, op_q;
    logic               accept, step, valid, div_q;
    logic               in_s1, in_s2, in_div0, in_ovf, in_special;
    logic [XLEN-1:0]    in_mag1, in_mag2, in_special_res;
    logic               neg_q, s1_q, special_q;
    logic [XLEN-1:0]    special_res_q, result_q;
    logic [RADDR_W-1:0] waddr_q, waddr_hold_q;
    logic [XLEN-1:0]    iter_hi, iter_lo, quo, rem, final_res;
    logic [2*XLEN-1:0]  prod;
    logic               iter_last;

    always_comb begin
        op_in   = op_e'(bus.op);
        in_s1   = op_rs1_signed(op_in) && bus.opv1[XLEN-1];
        in_s2   = op_rs2_signed(op_in) && bus.opv2[XLEN-1];
        in_mag1 = in_s1 ? -bus.opv1 : bus.opv1;
        in_mag2 = in_s2 ? -bus.opv2 : bus.opv2;
        in_div0 = op_is_div(op_in) && (bus.opv2 == '0);
        in_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM))
                  && (bus.opv1 == MIN_NEG) && (bus.opv2 == '1);
        in_special = in_div0 || in_ovf;
        if (in_div0) begin
            in_special_res = op_is_rem(op_in) ? bus.opv1 : '1;
        end else begin
            in_special_res = op_is_rem(op_in) ? '0 : bus.opv1;
        end
    end

    always_comb begin
        accept = (state == IDLE) && bus.start && !bus.cancel;
        step   = (state == CALC) && !bus.cancel;
        valid  = (state == DONE) && !bus.cancel;
        div_q  = op_is_div(op_q);
    end

    // Cancel overrides everything, including a start seen in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = in_special ? DONE : CALC;
            CALC: if (iter_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.cancel) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= OP_MUL;
            neg_q         <= 1'b0;
            s1_q          <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            waddr_q       <= '0;
        end else if (accept) begin
            op_q          <= op_in;
            neg_q         <= in_s1 ^ in_s2;
            s1_q          <= in_s1;
            special_q     <= in_special;
            special_res_q <= in_special_res;
            waddr_q       <= bus.reg_waddr_i;
        end
    end

    ex_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (step),
        .is_div (div_q),
        .a      (in_mag1),
        .b      (in_mag2),
        .hi     (iter_hi),
        .lo     (iter_lo),
        .last   (iter_last)
    );

    // Magnitudes come back from the iterator; signs are reapplied here.
    always_comb begin
        prod = {iter_hi, iter_lo};
        if (neg_q) prod = -prod;
        quo = neg_q ? -iter_lo : iter_lo;
        rem = s1_q  ? -iter_hi : iter_hi;
        case (op_q)
            OP_MUL:                        final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res = quo;
            default:                       final_res = rem;
        endcase
        if (special_q) final_res = special_res_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q     <= '0;
            waddr_hold_q <= '0;
        end else if (valid) begin
            result_q     <= final_res;
            waddr_hold_q <= waddr_q;
        end
    end

    assign bus.stallreq    = !rst && (accept || (state == CALC));
    assign bus.valid_o     = valid;
    assign bus.result      = valid ? final_res : result_q;
    assign bus.reg_waddr_o = valid ? waddr_q : waddr_hold_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv at XLEN=32 and XLEN=16 sharing one clock
// and reset; expected results come from a 64-bit reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  waddr;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    logic [31:0] last_res32;

    ex_muldiv_if #(.XLEN(32), .RADDR_W(5)) bus32 ();
    ex_muldiv_if #(.XLEN(16), .RADDR_W(5)) bus16 ();

    ex_muldiv #(.XLEN(32), .RADDR_W(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    ex_muldiv #(.XLEN(16), .RADDR_W(5)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic getValid(input int w);
        return (w == 32) ? bus32.valid_o : bus16.valid_o;
    endfunction

    function automatic logic getStall(input int w);
        return (w == 32) ? bus32.stallreq : bus16.stallreq;
    endfunction

    function automatic logic [31:0] getResult(input int w);
        return (w == 32) ? bus32.result : {16'h0, bus16.result};
    endfunction

    function automatic logic [4:0] getWaddr(input int w);
        return (w == 32) ? bus32.reg_waddr_o : bus16.reg_waddr_o;
    endfunction

    function automatic bit isSpecial(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask, ua, ub, minv;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        ua   = a & mask;
        ub   = b & mask;
        minv = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
        if (op[2] && ub == 0) return 1'b1;
        if ((op == 3'd4 || op == 3'd6) && ua == minv && ub == mask) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model works on sign-extended 64-bit values.
    function automatic logic [31:0] model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, p, res;
        longint      sa, sb, minv;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'h0, a} & mask;
        ub   = {32'h0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        minv = -(longint'(1) << (w - 1));
        res  = '0;
        case (op)
            3'd0: begin p = ua * ub;            res = p & mask; end
            3'd1: begin p = sa * sb;            res = (p >> w) & mask; end
            3'd2: begin p = sa * longint'(ub);  res = (p >> w) & mask; end
            3'd3: begin p = ua * ub;            res = (p >> w) & mask; end
            3'd4: begin
                if (ub == 0)                     res = mask;
                else if (sa == minv && sb == -1) res = ua;
                else begin p = sa / sb;          res = p & mask; end
            end
            3'd5: res = (ub == 0) ? mask : (ua / ub);
            3'd6: begin
                if (ub == 0)                     res = ua;
                else if (sa == minv && sb == -1) res = 0;
                else begin p = sa % sb;          res = p & mask; end
            end
            default: res = (ub == 0) ? ua : (ua % ub);
        endcase
        return res[31:0];
    endfunction

    task automatic driveBus(input int w, input logic s, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        if (w == 32) begin
            bus32.start = s; bus32.op = op; bus32.opv1 = a; bus32.opv2 = b; bus32.reg_waddr_i = wa;
        end else begin
            bus16.start = s; bus16.op = op; bus16.opv1 = a[15:0]; bus16.opv2 = b[15:0]; bus16.reg_waddr_i = wa;
        end
    endtask

    task automatic collectResult(input int w, input string tag, input bit poke);
        exp_t e;
        int   k;
        bit   seen;
        bit   stall_bad;
        e = exp_q.pop_front();
        seen = 1'b0;
        stall_bad = 1'b0;
        k = 0;
        while (!seen && k < w + 6) begin
            @(negedge clk);
            k++;
            if (poke && k == 3) driveBus(w, 1'b1, 3'd3, $urandom, $urandom, 5'd31);
            if (poke && k == 4) driveBus(w, 1'b0, 3'd0, $urandom, $urandom, 5'd0);
            #1;
            if (getStall(w) !== (k < e.lat)) stall_bad = 1'b1;
            if (getValid(w) === 1'b1) begin
                seen = 1'b1;
                checkOutput({tag, "_latency"}, 64'(k), 64'(e.lat));
                checkOutput({tag, "_result"}, {32'h0, getResult(w)}, {32'h0, e.res});
                checkOutput({tag, "_waddr"}, {59'h0, getWaddr(w)}, {59'h0, e.waddr});
            end
        end
        if (!seen) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        checkOutput({tag, "_stall"}, {63'h0, stall_bad}, 64'd0);
        if (seen) begin
            @(negedge clk);
            #1;
            checkOutput({tag, "_hold"}, {32'h0, getResult(w)}, {32'h0, e.res});
            checkOutput({tag, "_one_shot"}, {63'h0, getValid(w)}, 64'd0);
            if (w == 32) last_res32 = e.res;
        end
    endtask

    task automatic applyStimulus(input int w, input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wa, input bit poke);
        exp_t e;
        e.res   = model(w, op, a, b);
        e.waddr = wa;
        e.lat   = isSpecial(w, op, a, b) ? 1 : w + 1;
        exp_q.push_back(e);
        @(negedge clk);
        driveBus(w, 1'b1, op, a, b, wa);
        #1;
        checkOutput({tag, "_stall0"}, {63'h0, getStall(w)}, 64'd1);
        @(posedge clk);
        #1;
        driveBus(w, 1'b0, op, $urandom, $urandom, 5'($urandom));
        collectResult(w, tag, poke);
    endtask

    task automatic countValids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (bus32.valid_o === 1'b1) n++;
            if (bus16.valid_o === 1'b1) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail = 0;
        last_res32 = '0;
        rst = 1'b1;
        bus32.cancel = 1'b0;
        bus16.cancel = 1'b0;
        driveBus(32, 1'b1, 3'd0, 32'd7, 32'd3, 5'd9);
        driveBus(16, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", {63'h0, bus32.valid_o}, 64'd0);
        checkOutput("rst_stall", {63'h0, bus32.stallreq}, 64'd0);
        checkOutput("rst_result", {32'h0, bus32.result}, 64'd0);
        checkOutput("rst_waddr", {59'h0, bus32.reg_waddr_o}, 64'd0);
        driveBus(32, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        rst = 1'b0;
        $display("[TB] reset released");

        applyStimulus(32, "mul_7_m3",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  1'b1);
        applyStimulus(32, "mulhu_ones",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  1'b0);
        applyStimulus(32, "mulh_ones",   OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b0);
        applyStimulus(32, "mulhsu_m1",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  1'b0);
        applyStimulus(32, "div_m7_2",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd5,  1'b1);
        applyStimulus(32, "rem_m7_2",    OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  1'b0);
        applyStimulus(32, "divu_100_7",  OP_DIVU,   32'd100,        32'd7,         5'd7,  1'b0);
        applyStimulus(32, "remu_100_7",  OP_REMU,   32'd100,        32'd7,         5'd8,  1'b0);
        applyStimulus(32, "div_5_0",     OP_DIV,    32'd5,          32'd0,         5'd9,  1'b0);
        applyStimulus(32, "remu_5_0",    OP_REMU,   32'd5,          32'd0,         5'd10, 1'b0);
        applyStimulus(32, "rem_ovf",     OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1'b0);
        applyStimulus(32, "div_ovf",     OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            applyStimulus(32, "rand32", 3'($urandom_range(0, 7)), a, b, 5'($urandom), 1'b0);
        end

        // Cancel mid-CALC: no result may follow.
        @(negedge clk);
        driveBus(32, 1'b1, OP_MUL, 32'd123, 32'd456, 5'd20);
        @(posedge clk);
        #1;
        driveBus(32, 1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        repeat (10) @(negedge clk);
        bus32.cancel = 1'b1;
        #1;
        checkOutput("cancel_calc_valid", {63'h0, bus32.valid_o}, 64'd0);
        @(posedge clk);
        #1;
        bus32.cancel = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("cancel_idle_stall", {63'h0, bus32.stallreq}, 64'd0);
        countValids(40, n);
        checkOutput("cancel_no_valid", 64'(n), 64'd0);
        applyStimulus(32, "after_cancel", OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 1'b0);

        // Cancel in DONE suppresses valid_o and keeps the old result visible.
        @(negedge clk);
        driveBus(32, 1'b1, OP_DIVU, 32'd1000, 32'd3, 5'd22);
        @(posedge clk);
        #1;
        driveBus(32, 1'b0, OP_DIVU, 32'd0, 32'd0, 5'd0);
        repeat (33) @(negedge clk);
        #1;
        checkOutput("done_valid_pre", {63'h0, bus32.valid_o}, 64'd1);
        bus32.cancel = 1'b1;
        #1;
        checkOutput("done_cancel_valid", {63'h0, bus32.valid_o}, 64'd0);
        checkOutput("done_cancel_hold", {32'h0, bus32.result}, {32'h0, last_res32});
        @(posedge clk);
        #1;
        bus32.cancel = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("done_cancel_after", {63'h0, bus32.valid_o}, 64'd0);

        // Reset pulse mid-CALC.
        @(negedge clk);
        driveBus(32, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd23);
        @(posedge clk);
        #1;
        driveBus(32, 1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_result", {32'h0, bus32.result}, 64'd0);
        checkOutput("rst_mid_waddr", {59'h0, bus32.reg_waddr_o}, 64'd0);
        checkOutput("rst_mid_stall", {63'h0, bus32.stallreq}, 64'd0);
        checkOutput("rst_mid_valid", {63'h0, bus32.valid_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        countValids(40, n);
        checkOutput("rst_mid_no_valid", 64'(n), 64'd0);

        applyStimulus(16, "div16_m7_2",   OP_DIV,  32'h0000_FFF9, 32'd2,         5'd24, 1'b1);
        applyStimulus(16, "rem16_m7_2",   OP_REM,  32'h0000_FFF9, 32'd2,         5'd25, 1'b0);
        applyStimulus(16, "divu16_100_7", OP_DIVU, 32'd100,       32'd7,         5'd26, 1'b0);
        applyStimulus(16, "mulh16",       OP_MULH, 32'h0000_8000, 32'h0000_7FFF, 5'd27, 1'b0);
        applyStimulus(16, "rem16_ovf",    OP_REM,  32'h0000_8000, 32'h0000_FFFF, 5'd28, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16, "rand16", 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 1'b0);
        end

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
